mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port data Memory between two requesters: port 0 (CPU load/store)
//  and port 1 (DMA/debug loader). Round-robin arbitration, one transaction in flight.
//  Drives the Memory's rd/wn/address/mode/write_data strobes. Bounds-checks addresses
//  and returns read data or error over per-port valid/ready response channels.
// PARAMETERS
//  MEM_BYTES  2048  byte capacity of the attached Memory; legal byte addresses are 0..MEM_BYTES-1
//  ADDR_W     16    address width
//  DATA_W     16    data width; byte mode uses bits [7:0]
// PORTS
//  clk             in   1       single clock; all state updates on posedge
//  rst             in   1       synchronous, active-high reset
//  reqN_valid      in   1       N=0,1: request valid
//  reqN_ready      out  1       request accepted this cycle when valid&ready
//  reqN_we         in   1       1=write, 0=read
//  reqN_mode       in   1       0=word (2 bytes, big-endian: addr=MSB), 1=byte
//  reqN_addr       in   ADDR_W  byte address
//  reqN_wdata      in   DATA_W  write data
//  rspN_valid      out  1       response valid; held until rspN_ready
//  rspN_ready      in   1       requester takes response
//  rspN_rdata      out  DATA_W  read data; byte reads zero-extended; 0 for writes and errors
//  rspN_err        out  1       1 = out-of-range access, no memory access performed
//  mem_rd          out  1       to Memory rd
//  mem_wn          out  1       to Memory wn
//  mem_mode        out  2       to Memory mode ({1'b0, mode})
//  mem_address     out  ADDR_W  to Memory address
//  mem_write_data  out  DATA_W  to Memory write_data
//  mem_read_data   in   DATA_W  from Memory read_data (registered in Memory on posedge)
// BEHAVIOUR
//  - States: IDLE, CMD, CAPTURE, RESP. Reset -> IDLE.
//  - Reset values: all reqN_ready/rspN_valid/rspN_err=0, rspN_rdata=0, mem_rd=mem_wn=0,
//    mem_address/mem_write_data/mem_mode=0, rr pointer = port 0 preferred.
//  - IDLE: reqN_ready is combinational; high only for the granted port, only in IDLE.
//    If only one port is valid, grant it. If both, grant the rr-preferred port;
//    pointer flips to the other port on every accept. Accept latches we/mode/addr/wdata/port.
//  - Range check on accept: err if addr>=MEM_BYTES, or word mode and addr>=MEM_BYTES-1.
//    err -> RESP directly (rsp_err=1, rdata=0), no mem strobe ever asserted.
//  - CMD (exactly 1 cycle): registered outputs mem_rd=~we, mem_wn=we, address/mode/wdata
//    from latch. Never rd=wn=1. Writes commit at the Memory's negedge inside CMD.
//    Write -> RESP; read -> CAPTURE.
//  - CAPTURE (1 cycle): strobes low; mem_read_data now valid; registered into rsp_rdata;
//    byte mode masks to {8'h00, mem_read_data[7:0]}. -> RESP.
//  - RESP: rsp_valid high on granted port only; outputs stable until rspN_ready; on
//    valid&ready -> IDLE; new request acceptable the following cycle.
//  - Latency (accept edge = cycle 0): write rsp_valid in cycle 2, read in cycle 3,
//    error in cycle 1. Throughput: at most one transaction per 3 (wr) / 4 (rd) cycles.
//  - Strobes are low in every state except CMD; mem_address holds its last value.
//  - Non-granted port sees reqN_ready=0 and rspN_valid=0; its request must stay stable.
//  - Reset mid-operation: in-flight transaction dropped, no response issued; if rst
//    is sampled in CMD, the negedge write of that cycle has already occurred.
//  - Address 0xFFFF and address wrap: never wrap; flagged as error by the range check.
// TESTING
//  1 Port0 word write addr=0x0010 data=0xBEEF, then word read 0x0010 -> rsp0 cycle 3, rdata=0xBEEF, err=0.
//  2 Byte write 0x0011 data=0x1234, word read 0x0010 -> 0xBE34; byte read 0x0011 -> 0x0034.
//  3 Both ports valid in the same cycle, held for 4 transactions -> grants alternate 0,1,0,1; no overlap of mem strobes.
//  4 Word read 0x07FF and byte read 0x0800 -> err=1, rdata=0, response in cycle 1, mem_rd/mem_wn never asserted.
//  5 rsp0_ready held low 5 cycles -> rsp0_valid/rdata stable; port1 request stalls (ready=0) until release.
//  6 rst asserted in CAPTURE -> next cycle IDLE, all outputs at reset values, no rsp_valid; next request serviced normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-port byte Memory between two requesters.
// One transaction in flight; range-checked requests; per-port valid/ready responses.
module mem_arbiter #(
  parameter int MEM_BYTES = 2048,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic              req0_mode,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic              req1_mode,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic              mem_rd,
  output logic              mem_wn,
  output logic [1:0]        mem_mode,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t              state_r;
  state_t              next_state_s;

  logic                rr_r;          // preferred port when both request
  logic                port_r;        // port owning the in-flight transaction
  logic                we_r;
  logic                mode_r;

  logic                grant_s;
  logic                accept_s;
  logic                sel_we_s;
  logic                sel_mode_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic                sel_err_s;
  logic                rsp_fire_s;

  logic                rsp0_valid_r;
  logic                rsp1_valid_r;
  logic                rsp_err_r;
  logic [DATA_W-1:0]   rsp_rdata_r;
  logic                mem_rd_r;
  logic                mem_wn_r;
  logic                mem_mode_r;
  logic [ADDR_W-1:0]   mem_address_r;
  logic [DATA_W-1:0]   mem_write_data_r;

  // Out of range when the byte (or the second byte of a word) lies past the Memory.
  // Addresses are never wrapped, so 0xFFFF always fails here.
  function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr,
                                             input logic byte_mode);
    logic [31:0] a;
    a = 32'(addr);
    if (a >= 32'(MEM_BYTES)) begin
      return 1'b1;
    end else if (!byte_mode && (a >= 32'(MEM_BYTES - 1))) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

  // Grant selection: a lone requester wins, a tie goes to the round-robin favourite.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = rr_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Request mux for the granted port plus the range check of that request.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_mode_s  = 1'b0;
    sel_addr_s  = {ADDR_W{1'b0}};
    sel_wdata_s = {DATA_W{1'b0}};
    if (grant_s) begin
      sel_we_s    = req1_we;
      sel_mode_s  = req1_mode;
      sel_addr_s  = req1_addr;
      sel_wdata_s = req1_wdata;
    end else begin
      sel_we_s    = req0_we;
      sel_mode_s  = req0_mode;
      sel_addr_s  = req0_addr;
      sel_wdata_s = req0_wdata;
    end
    sel_err_s = addr_out_of_range(sel_addr_s, sel_mode_s);
  end

  assign accept_s   = (state_r == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = (state_r == IDLE) && req0_valid && !grant_s;
  assign req1_ready = (state_r == IDLE) && req1_valid && grant_s;
  assign rsp_fire_s = port_r ? (rsp1_valid_r && rsp1_ready) : (rsp0_valid_r && rsp0_ready);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: errors skip the Memory, writes skip the capture cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = sel_err_s ? RESP : CMD;
        end else begin
          next_state_s = IDLE;
        end
      end
      CMD:     next_state_s = we_r ? RESP : CAPTURE;
      CAPTURE: next_state_s = RESP;
      RESP: begin
        if (rsp_fire_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Transaction latch, Memory strobes and response registers.
  // Strobes default low each cycle so they are high only during CMD.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_r             <= 1'b0;
      port_r           <= 1'b0;
      we_r             <= 1'b0;
      mode_r           <= 1'b0;
      rsp0_valid_r     <= 1'b0;
      rsp1_valid_r     <= 1'b0;
      rsp_err_r        <= 1'b0;
      rsp_rdata_r      <= {DATA_W{1'b0}};
      mem_rd_r         <= 1'b0;
      mem_wn_r         <= 1'b0;
      mem_mode_r       <= 1'b0;
      mem_address_r    <= {ADDR_W{1'b0}};
      mem_write_data_r <= {DATA_W{1'b0}};
    end else begin
      mem_rd_r <= 1'b0;
      mem_wn_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            port_r      <= grant_s;
            we_r        <= sel_we_s;
            mode_r      <= sel_mode_s;
            rr_r        <= ~grant_s;
            rsp_rdata_r <= {DATA_W{1'b0}};
            if (sel_err_s) begin
              rsp_err_r    <= 1'b1;
              rsp0_valid_r <= ~grant_s;
              rsp1_valid_r <= grant_s;
            end else begin
              rsp_err_r        <= 1'b0;
              mem_rd_r         <= ~sel_we_s;
              mem_wn_r         <= sel_we_s;
              mem_address_r    <= sel_addr_s;
              mem_mode_r       <= sel_mode_s;
              mem_write_data_r <= sel_wdata_s;
            end
          end
        end
        CMD: begin
          if (we_r) begin
            rsp0_valid_r <= ~port_r;
            rsp1_valid_r <= port_r;
          end
        end
        CAPTURE: begin
          if (mode_r) begin
            rsp_rdata_r <= {{(DATA_W-8){1'b0}}, mem_read_data[7:0]};
          end else begin
            rsp_rdata_r <= mem_read_data;
          end
          rsp0_valid_r <= ~port_r;
          rsp1_valid_r <= port_r;
        end
        RESP: begin
          if (rsp_fire_s) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
          end
        end
        default: begin
          rsp0_valid_r <= 1'b0;
          rsp1_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign rsp0_valid     = rsp0_valid_r;
  assign rsp1_valid     = rsp1_valid_r;
  assign rsp0_err       = rsp_err_r;
  assign rsp1_err       = rsp_err_r;
  assign rsp0_rdata     = rsp_rdata_r;
  assign rsp1_rdata     = rsp_rdata_r;
  assign mem_rd         = mem_rd_r;
  assign mem_wn         = mem_wn_r;
  assign mem_mode       = {1'b0, mem_mode_r};
  assign mem_address    = mem_address_r;
  assign mem_write_data = mem_write_data_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a byte-array Memory model on the strobes,
// and an independent reference byte array predicting every response.
module tb_mem_arbiter;

  localparam int MEM_BYTES = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [1:0]  req_we = 2'b00;
  logic [1:0]  req_mode = 2'b00;
  logic [15:0] req_addr [2];
  logic [15:0] req_wdata [2];
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [15:0] rsp_rdata [2];
  logic [1:0]  rsp_err;
  logic        mem_rd;
  logic        mem_wn;
  logic [1:0]  mem_mode;
  logic [15:0] mem_address;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data = 16'h0000;

  logic        init_phase = 1'b1;
  logic [7:0]  mem_model [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  int          rd_cnt = 0;
  int          wn_cnt = 0;
  int          both_cnt = 0;
  int          rsp_both_cnt = 0;
  int          rdy_both_cnt = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_BYTES(MEM_BYTES), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_we(req_we[0]),
    .req0_mode(req_mode[0]), .req0_addr(req_addr[0]), .req0_wdata(req_wdata[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_we(req_we[1]),
    .req1_mode(req_mode[1]), .req1_addr(req_addr[1]), .req1_wdata(req_wdata[1]),
    .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_rdata(rsp_rdata[0]),
    .rsp0_err(rsp_err[0]),
    .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_rdata(rsp_rdata[1]),
    .rsp1_err(rsp_err[1]),
    .mem_rd(mem_rd), .mem_wn(mem_wn), .mem_mode(mem_mode), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Memory model: preload pattern, big-endian word writes on negedge.
  always @(negedge clk) begin
    if (init_phase) begin
      for (int i = 0; i < MEM_BYTES; i++) mem_model[i] <= 8'((i * 37 + 11) & 255);
    end else if (mem_wn) begin
      if (mem_mode[0]) begin
        if (int'(mem_address) < MEM_BYTES) mem_model[int'(mem_address)] <= mem_write_data[7:0];
      end else if (int'(mem_address) + 1 < MEM_BYTES) begin
        mem_model[int'(mem_address)]     <= mem_write_data[15:8];
        mem_model[int'(mem_address) + 1] <= mem_write_data[7:0];
      end
    end
  end

  // Memory model: registered read; byte reads carry junk in the upper byte.
  always @(posedge clk) begin
    if (mem_rd && int'(mem_address) + 1 < MEM_BYTES) begin
      if (mem_mode[0]) mem_read_data <= {8'hA5, mem_model[int'(mem_address)]};
      else mem_read_data <= {mem_model[int'(mem_address)], mem_model[int'(mem_address) + 1]};
    end else if (mem_rd && int'(mem_address) < MEM_BYTES) begin
      mem_read_data <= {8'hA5, mem_model[int'(mem_address)]};
    end
  end

  // Strobe and handshake monitor.
  always @(negedge clk) begin
    if (mem_rd) rd_cnt <= rd_cnt + 1;
    if (mem_wn) wn_cnt <= wn_cnt + 1;
    if (mem_rd && mem_wn) both_cnt <= both_cnt + 1;
    if (rsp_valid == 2'b11) rsp_both_cnt <= rsp_both_cnt + 1;
    if (req_ready == 2'b11) rdy_both_cnt <= rdy_both_cnt + 1;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One complete transaction on port p with rsp ready held low for 'hold' cycles.
  task automatic do_txn(input int p, input logic we, input logic md, input logic [15:0] a,
                        input logic [15:0] wd, input int hold);
    int          ai;
    int          rd0;
    int          wn0;
    int          k;
    int          exp_lat;
    logic        exp_e;
    logic [15:0] exp_d;
    logic [15:0] held_d;
    bit          got;
    ai    = int'(a);
    exp_e = (ai >= MEM_BYTES) || (!md && ai >= MEM_BYTES - 1);
    exp_d = 16'h0000;
    if (!exp_e) begin
      if (we) begin
        if (md) ref_mem[ai] = wd[7:0];
        else begin
          ref_mem[ai]     = wd[15:8];
          ref_mem[ai + 1] = wd[7:0];
        end
      end else begin
        exp_d = md ? {8'h00, ref_mem[ai]} : {ref_mem[ai], ref_mem[ai + 1]};
      end
    end
    exp_lat = exp_e ? 1 : (we ? 2 : 3);
    req_valid[p] = 1'b1;
    req_we[p]    = we;
    req_mode[p]  = md;
    req_addr[p]  = a;
    req_wdata[p] = wd;
    #1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (req_ready[p]) got = 1'b1;
      else step();
    end
    rd0 = rd_cnt;
    wn0 = wn_cnt;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL accept: port %0d ready got 0 required 1", p);
    end
    step();
    req_valid[p] = 1'b0;
    k = 1;
    while (!rsp_valid[p] && k < 10) begin
      step();
      k++;
    end
    tests++;
    if (k !== exp_lat) begin
      fails++;
      $display("FAIL latency: port %0d addr %h got %0d required %0d", p, a, k, exp_lat);
    end
    tests++;
    if (rsp_rdata[p] !== exp_d || rsp_err[p] !== exp_e) begin
      fails++;
      $display("FAIL rsp: port %0d addr %h we %0b mode %0b got data %h err %0b required data %h err %0b",
               p, a, we, md, rsp_rdata[p], rsp_err[p], exp_d, exp_e);
    end
    tests++;
    if (rsp_valid[1-p] !== 1'b0 || (rd_cnt - rd0) !== int'(!exp_e && !we) ||
        (wn_cnt - wn0) !== int'(!exp_e && we)) begin
      fails++;
      $display("FAIL strobes: port %0d other_valid %0b rd %0d wn %0d required rd %0d wn %0d",
               p, rsp_valid[1-p], rd_cnt - rd0, wn_cnt - wn0, int'(!exp_e && !we), int'(!exp_e && we));
    end
    held_d = rsp_rdata[p];
    for (int i = 0; i < hold; i++) begin
      step();
      tests++;
      if (rsp_valid[p] !== 1'b1 || rsp_rdata[p] !== held_d || req_ready[1-p] !== 1'b0) begin
        fails++;
        $display("FAIL hold: cycle %0d valid %0b data %h other_ready %0b required 1 %h 0",
                 i, rsp_valid[p], rsp_rdata[p], req_ready[1-p], held_d);
      end
    end
    rsp_ready[p] = 1'b1;
    step();
    rsp_ready[p] = 1'b0;
    tests++;
    if (rsp_valid[p] !== 1'b0) begin
      fails++;
      $display("FAIL release: port %0d valid got %0b required 0", p, rsp_valid[p]);
    end
  endtask

  task automatic check_reset_values(input string tag);
    tests++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata[0], rsp_rdata[1], mem_rd, mem_wn,
         mem_mode, mem_address, mem_write_data} !== 80'h0) begin
      fails++;
      $display("FAIL %s: outputs ready %b valid %b err %b rdata %h/%h rd %b wn %b mode %b addr %h wd %h required all 0",
               tag, req_ready, rsp_valid, rsp_err, rsp_rdata[0], rsp_rdata[1], mem_rd, mem_wn,
               mem_mode, mem_address, mem_write_data);
    end
  endtask

  task automatic test_reset();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    rst = 1'b1;
    step();
    step();
    check_reset_values("reset_held");
    rst = 1'b0;
    step();
    check_reset_values("reset_idle");
  endtask

  task automatic test_word_byte();
    do_txn(0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 0);
    do_txn(0, 1'b0, 1'b0, 16'h0010, 16'h0000, 0);
    do_txn(0, 1'b1, 1'b1, 16'h0011, 16'h1234, 0);
    do_txn(0, 1'b0, 1'b0, 16'h0010, 16'h0000, 0);
    do_txn(0, 1'b0, 1'b1, 16'h0011, 16'h0000, 0);
  endtask

  task automatic test_range();
    do_txn(0, 1'b0, 1'b0, 16'h07FF, 16'h0000, 0);
    do_txn(1, 1'b0, 1'b1, 16'h0800, 16'h0000, 0);
    do_txn(0, 1'b1, 1'b0, 16'hFFFF, 16'h5555, 0);
    do_txn(1, 1'b1, 1'b0, 16'h07FE, 16'hCAFE, 0);
    do_txn(0, 1'b0, 1'b1, 16'h07FF, 16'h0000, 0);
    do_txn(1, 1'b0, 1'b0, 16'h07FE, 16'h0000, 0);
  endtask

  task automatic test_round_robin();
    int          g[$];
    int          bad;
    logic [15:0] e0;
    logic [15:0] e1;
    test_reset();
    e0 = {ref_mem[32], ref_mem[33]};
    e1 = {8'h00, ref_mem[48]};
    bad = 0;
    req_we = 2'b00;
    req_mode = 2'b10;
    req_addr[0] = 16'h0020;
    req_addr[1] = 16'h0030;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 60 && g.size() < 4; i++) begin
      if (req_ready[0]) g.push_back(0);
      else if (req_ready[1]) g.push_back(1);
      if (rsp_valid[0] && rsp_rdata[0] !== e0) bad++;
      if (rsp_valid[1] && rsp_rdata[1] !== e1) bad++;
      step();
    end
    req_valid = 2'b00;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid[0] && rsp_rdata[0] !== e0) bad++;
      if (rsp_valid[1] && rsp_rdata[1] !== e1) bad++;
      step();
    end
    rsp_ready = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (i >= g.size() || g[i] !== (i % 2)) begin
        fails++;
        $display("FAIL rr_grant: index %0d got %0d required %0d", i, (i < g.size()) ? g[i] : -1, i % 2);
      end
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL rr_data: got %0d bad responses required 0", bad);
    end
  endtask

  task automatic test_backpressure();
    do_txn(1, 1'b0, 1'b1, 16'h0040, 16'h0000, 0);
    req_we[1]    = 1'b0;
    req_mode[1]  = 1'b0;
    req_addr[1]  = 16'h0050;
    req_wdata[1] = 16'h0000;
    req_valid[1] = 1'b1;
    do_txn(0, 1'b0, 1'b0, 16'h0010, 16'h0000, 5);
    do_txn(1, 1'b0, 1'b0, 16'h0050, 16'h0000, 0);
  endtask

  task automatic test_reset_mid();
    req_we[0] = 1'b0;
    req_mode[0] = 1'b0;
    req_addr[0] = 16'h0010;
    req_valid[0] = 1'b1;
    #1;
    tests++;
    if (req_ready[0] !== 1'b1) begin
      fails++;
      $display("FAIL mid_accept: ready got %0b required 1", req_ready[0]);
    end
    step();
    req_valid[0] = 1'b0;
    step();
    rst = 1'b1;
    step();
    check_reset_values("reset_capture");
    rst = 1'b0;
    step();
    check_reset_values("after_reset_capture");
    do_txn(0, 1'b0, 1'b0, 16'h0010, 16'h0000, 0);
  endtask

  task automatic test_random();
    int          p;
    int          pick;
    logic [15:0] a;
    for (int n = 0; n < 40; n++) begin
      p = int'($urandom_range(0, 1));
      pick = int'($urandom_range(0, 9));
      if (pick == 0) a = 16'(2040 + $urandom_range(0, 15));
      else if (pick == 1) a = 16'($urandom);
      else a = 16'($urandom_range(0, 2047));
      do_txn(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom),
             int'($urandom_range(0, 2)));
    end
    tests++;
    if (both_cnt !== 0 || rsp_both_cnt !== 0 || rdy_both_cnt !== 0) begin
      fails++;
      $display("FAIL overlap: rd&wn %0d rsp both %0d ready both %0d required 0 0 0",
               both_cnt, rsp_both_cnt, rdy_both_cnt);
    end
  endtask

  initial begin
    req_addr[0] = 16'h0000;
    req_addr[1] = 16'h0000;
    req_wdata[0] = 16'h0000;
    req_wdata[1] = 16'h0000;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'((i * 37 + 11) & 255);
    step();
    init_phase = 1'b0;
    test_reset();
    test_word_byte();
    test_range();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
